// File: rtl/game_time_counter.sv
// Loadable MM:SS BCD countdown timer for the game-timer FSM.
// Arithmetic runs on binary minutes/seconds; registered digits are kept as BCD.
module game_time_counter #(
   parameter int unsigned TICK_CYCLES = 31_500_000,
   parameter logic [15:0] LOAD_VALUE  = 16'h0130,
   parameter int unsigned BONUS_SEC   = 5,
   parameter int unsigned LOW_SEC     = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       countLoadN,
   input  logic       countEnable,
   input  logic       bonusPulse,
   output logic       timerEnd,
   output logic       tickOut,
   output logic       lowTime,
   output logic [3:0] minTens,
   output logic [3:0] minOnes,
   output logic [3:0] secTens,
   output logic [3:0] secOnes
);

   localparam int unsigned PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);
   localparam logic [6:0] BONUS7     = 7'(BONUS_SEC);
   localparam logic [6:0] LOW7       = 7'(LOW_SEC);
   localparam logic [6:0] LOAD_MIN   = 7'(LOAD_VALUE[15:12]) * 7'd10 + 7'(LOAD_VALUE[11:8]);
   localparam logic [6:0] LOAD_SEC   = 7'(LOAD_VALUE[7:4]) * 7'd10 + 7'(LOAD_VALUE[3:0]);
   localparam logic       LOAD_ZERO  = (LOAD_VALUE == 16'h0000);
   localparam logic       LOAD_LOW   = (LOAD_MIN == 7'd0) && (LOAD_SEC != 7'd0) && (LOAD_SEC <= LOW7);

   if (LOAD_VALUE[7:4] > 4'd5 || TICK_CYCLES < 2 || BONUS_SEC > 59 || LOW_SEC < 1 || LOW_SEC > 59)
   begin : g_bad_params
      $error("game_time_counter: illegal parameter value");
   end

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_EXPIRED} state_t;

   state_t        state_q, state_d;
   logic [15:0]   digits_q, digits_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          timer_end_q, timer_end_d;
   logic          tick_q, tick_d;
   logic          low_q, low_d;

   logic          tick_now, bonus_now;
   logic [6:0]    min_cur, sec_cur, min_new, sec_new;

   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   assign tick_now  = (state_q == S_ACTIVE) && countEnable && (presc_q == PRESC_MAX);
   assign bonus_now = (state_q == S_ACTIVE) && bonusPulse;
   assign min_cur   = 7'(digits_q[15:12]) * 7'd10 + 7'(digits_q[11:8]);
   assign sec_cur   = 7'(digits_q[7:4]) * 7'd10 + 7'(digits_q[3:0]);

   // Decrement first, then add the bonus, so a coincident pair yields time-1+BONUS.
   always_comb begin
      min_new = min_cur;
      sec_new = sec_cur;
      if (tick_now) begin
         if (sec_new == 7'd0) begin
            sec_new = 7'd59;
            min_new = min_new - 7'd1;
         end else begin
            sec_new = sec_new - 7'd1;
         end
      end
      if (bonus_now) begin
         sec_new = sec_new + BONUS7;
         if (sec_new >= 7'd60) begin
            sec_new = sec_new - 7'd60;
            min_new = min_new + 7'd1;
         end
         if (min_new > 7'd99) begin
            min_new = 7'd99;
            sec_new = 7'd59;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      digits_d    = digits_q;
      presc_d     = presc_q;
      timer_end_d = timer_end_q;
      tick_d      = 1'b0;
      low_d       = low_q;
      if (!countLoadN) begin
         digits_d    = LOAD_VALUE;
         presc_d     = '0;
         timer_end_d = LOAD_ZERO;
         low_d       = LOAD_LOW;
         state_d     = LOAD_ZERO ? S_EXPIRED : S_ACTIVE;
      end else begin
         case (state_q)
            S_ACTIVE: begin
               if (countEnable) begin
                  presc_d = tick_now ? '0 : presc_q + PW'(1);
               end
               tick_d   = tick_now;
               digits_d = {to_bcd(min_new), to_bcd(sec_new)};
               if (min_new == 7'd0 && sec_new == 7'd0) begin
                  state_d     = S_EXPIRED;
                  timer_end_d = 1'b1;
                  low_d       = 1'b0;
               end else begin
                  low_d = (min_new == 7'd0) && (sec_new <= LOW7);
               end
            end
            S_EXPIRED: begin
               digits_d    = '0;
               timer_end_d = 1'b1;
               low_d       = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         digits_q    <= '0;
         presc_q     <= '0;
         timer_end_q <= 1'b0;
         tick_q      <= 1'b0;
         low_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         digits_q    <= digits_d;
         presc_q     <= presc_d;
         timer_end_q <= timer_end_d;
         tick_q      <= tick_d;
         low_q       <= low_d;
      end
   end

   assign timerEnd = timer_end_q;
   assign tickOut  = tick_q;
   assign lowTime  = low_q;
   assign minTens  = digits_q[15:12];
   assign minOnes  = digits_q[11:8];
   assign secTens  = digits_q[7:4];
   assign secOnes  = digits_q[3:0];

endmodule
